// File: rtl/u110_ata_pkg.sv
// rtl/u110_ata_pkg.sv - shared states, PIO timing tables and mode clamp for the ATA PIO sequencer
package u110_ata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_DONE,
    ST_RECOVER
  } state_t;

  // IORDY wait limit in 25 ns cycles (1250 ns)
  localparam logic [5:0] TIMEOUT = 6'd50;

  // Modes above 4 behave as the fastest supported mode
  function automatic logic [2:0] clamp_mode(input logic [2:0] m);
    return (m > 3'd4) ? 3'd4 : m;
  endfunction

  // Address setup (T1) cycles per clamped mode
  function automatic logic [3:0] t1_of(input logic [2:0] m);
    case (m)
      3'd0:       return 4'd3;
      3'd1, 3'd2: return 4'd2;
      default:    return 4'd1;
    endcase
  endfunction

  // Strobe low (T2) cycles per clamped mode
  function automatic logic [3:0] t2_of(input logic [2:0] m);
    case (m)
      3'd0:       return 4'd7;
      3'd1:       return 4'd6;
      3'd2, 3'd3: return 4'd4;
      default:    return 4'd3;
    endcase
  endfunction

  // Recovery cycles per clamped mode; T1+T2+TREC gives the cycle time t0
  function automatic logic [3:0] trec_of(input logic [2:0] m);
    case (m)
      3'd0:    return 4'd10;
      3'd1:    return 4'd8;
      3'd2:    return 4'd4;
      3'd3:    return 4'd3;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/u110_ata_pio_sequencer_if.sv
// rtl/u110_ata_pio_sequencer_if.sv - CPU-side request and ATA-side control signals of the PIO sequencer
interface u110_ata_pio_sequencer_if;
  logic       ATA_CYC;
  logic       RnW;
  logic [2:0] PIO_MODE;
  logic       IORDY_EN;
  logic       IORDY;
  logic       ATA_CS_EN;
  logic       ATA_DIORn;
  logic       ATA_DIOWn;
  logic       DATA_OE;
  logic       DATA_LATCH;
  logic       ATA_TACK;
  logic       ATA_TEA;

  modport master (
    output ATA_CYC, RnW, PIO_MODE, IORDY_EN, IORDY,
    input  ATA_CS_EN, ATA_DIORn, ATA_DIOWn, DATA_OE, DATA_LATCH, ATA_TACK, ATA_TEA
  );

  modport slave (
    input  ATA_CYC, RnW, PIO_MODE, IORDY_EN, IORDY,
    output ATA_CS_EN, ATA_DIORn, ATA_DIOWn, DATA_OE, DATA_LATCH, ATA_TACK, ATA_TEA
  );
endinterface

// File: rtl/u110_sync2.sv
// rtl/u110_sync2.sv - two-flop synchroniser for an asynchronous input pin
module u110_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops give metastability a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/u110_ata_pio_sequencer.sv
// rtl/u110_ata_pio_sequencer.sv - one ATA PIO transfer per CPU request with IORDY wait and timeout
module u110_ata_pio_sequencer
  import u110_ata_pkg::*;
(
  input logic                     CLK40,
  input logic                     RESET,
  u110_ata_pio_sequencer_if.slave bus
);
  state_t     state;
  logic [3:0] cnt;
  logic [5:0] tcnt;
  logic       rnw_q;
  logic       iordy_en_q;
  logic [2:0] mode_q;
  logic       iordy_s;
  logic       abort;
  logic [2:0] mode_in;

  logic cs_en, dior_n, diow_n, data_oe, data_latch, tack, tea;

  u110_sync2 u_iordy_sync (
    .clk (CLK40),
    .rst (RESET),
    .d   (bus.IORDY),
    .q   (iordy_s)
  );

  assign mode_in = clamp_mode(bus.PIO_MODE);
  assign abort   = !bus.ATA_CYC &&
                   (state == ST_SETUP || state == ST_STROBE || state == ST_WAIT);

  assign bus.ATA_CS_EN  = cs_en;
  assign bus.ATA_DIORn  = dior_n;
  assign bus.ATA_DIOWn  = diow_n;
  assign bus.DATA_OE    = data_oe;
  assign bus.DATA_LATCH = data_latch;
  assign bus.ATA_TACK   = tack;
  assign bus.ATA_TEA    = tea;

  // Transfer FSM; every output is a register so the bus buffers see glitch-free controls.
  // The phase counter never steps below 1, so it cannot wrap.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      tcnt       <= 6'd0;
      rnw_q      <= 1'b1;
      iordy_en_q <= 1'b0;
      mode_q     <= 3'd0;
      cs_en      <= 1'b0;
      dior_n     <= 1'b1;
      diow_n     <= 1'b1;
      data_oe    <= 1'b0;
      data_latch <= 1'b0;
      tack       <= 1'b0;
      tea        <= 1'b0;
    end else begin
      data_latch <= 1'b0;
      if (abort) begin
        // CPU gave up: release the bus quietly, still honour recovery time
        dior_n  <= 1'b1;
        diow_n  <= 1'b1;
        cs_en   <= 1'b0;
        data_oe <= 1'b0;
        cnt     <= trec_of(mode_q);
        state   <= ST_RECOVER;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.ATA_CYC && cnt == 4'd0 && !tack && !tea) begin
              rnw_q      <= bus.RnW;
              mode_q     <= mode_in;
              iordy_en_q <= bus.IORDY_EN;
              cnt        <= t1_of(mode_in);
              cs_en      <= 1'b1;
              data_oe    <= !bus.RnW;
              state      <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (cnt <= 4'd1) begin
              dior_n <= !rnw_q;
              diow_n <= rnw_q;
              cnt    <= t2_of(mode_q);
              state  <= ST_STROBE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_STROBE: begin
            if (cnt <= 4'd1) begin
              // last strobe-low cycle has elapsed: negate and request termination
              dior_n <= 1'b1;
              diow_n <= 1'b1;
              tack   <= 1'b1;
              state  <= ST_DONE;
            end else if (cnt == 4'd2 && iordy_en_q && !iordy_s) begin
              // device not ready: keep the strobe low instead of entering the final cycle
              tcnt  <= 6'd0;
              state <= ST_WAIT;
            end else begin
              if (cnt == 4'd2) data_latch <= rnw_q;
              cnt <= cnt - 4'd1;
            end
          end
          ST_WAIT: begin
            if (iordy_s) begin
              // one final strobe-low cycle, with read data captured in it
              data_latch <= rnw_q;
              cnt        <= 4'd1;
              state      <= ST_STROBE;
            end else if (tcnt >= TIMEOUT - 6'd1) begin
              dior_n <= 1'b1;
              diow_n <= 1'b1;
              tea    <= 1'b1;
              state  <= ST_DONE;
            end else if (tcnt != 6'h3f) begin
              tcnt <= tcnt + 6'd1;
            end
          end
          ST_DONE: begin
            // chip select and write data held for one cycle past strobe negation
            cs_en   <= 1'b0;
            data_oe <= 1'b0;
            if (!bus.ATA_CYC) begin
              tack  <= 1'b0;
              tea   <= 1'b0;
              cnt   <= trec_of(mode_q);
              state <= ST_RECOVER;
            end
          end
          ST_RECOVER: begin
            if (cnt <= 4'd1) begin
              cnt   <= 4'd0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_u110_ata_pio_sequencer.sv
// tb/tb_u110_ata_pio_sequencer.sv - self-checking bench for the ATA PIO sequencer
module tb_u110_ata_pio_sequencer;
  logic CLK40 = 1'b0;
  logic RESET = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_fall = 0;

  u110_ata_pio_sequencer_if bus ();

  u110_ata_pio_sequencer dut (
    .CLK40 (CLK40),
    .RESET (RESET),
    .bus   (bus)
  );

  always #12 CLK40 = ~CLK40;

  always @(posedge CLK40) cyc <= cyc + 1;

  function automatic int clampm(input int m);
    return (m > 4) ? 4 : m;
  endfunction

  function automatic int t1m(input int m);
    int t[5] = '{3, 2, 2, 1, 1};
    return t[clampm(m)];
  endfunction

  function automatic int t2m(input int m);
    int t[5] = '{7, 6, 4, 4, 3};
    return t[clampm(m)];
  endfunction

  function automatic int t0m(input int m);
    int t[5] = '{20, 16, 10, 8, 5};
    return t[clampm(m)];
  endfunction

  function automatic logic [6:0] outs();
    return {bus.ATA_CS_EN, bus.ATA_DIORn, bus.ATA_DIOWn, bus.DATA_OE,
            bus.DATA_LATCH, bus.ATA_TACK, bus.ATA_TEA};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK40);
  endtask

  // hold: -1 = IORDY high, N = IORDY low until strobe low T2+N cycles, >=1000 = stuck low
  task automatic run_xfer(input int mode, input bit rnw, input bit ioen, input int hold,
                          input bit chk_cs);
    int t1, t2, k, cs_at, fall_at, low_n, latch_at, latch_n, oe_bad, wrong_n, both, lo, hi;
    bit to_exp, ended, wait_exp;
    logic strobe, other;
    t1 = t1m(mode);
    t2 = t2m(mode);
    to_exp   = ioen && hold >= 1000;
    wait_exp = ioen && hold >= 0;
    k = 0; cs_at = -1; fall_at = -1; low_n = 0; latch_at = -1; latch_n = 0;
    oe_bad = 0; wrong_n = 0; both = 0; ended = 0; strobe = 1'b1;
    bus.RnW      = rnw;
    bus.PIO_MODE = 3'(mode);
    bus.IORDY_EN = ioen;
    bus.IORDY    = (hold >= 0) ? 1'b0 : 1'b1;
    if (chk_cs) idle(12);
    bus.ATA_CYC = 1'b1;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge CLK40);
      k++;
      if (cs_at < 0 && bus.ATA_CS_EN) cs_at = k;
      strobe = rnw ? bus.ATA_DIORn : bus.ATA_DIOWn;
      other  = rnw ? bus.ATA_DIOWn : bus.ATA_DIORn;
      if (!other) wrong_n++;
      if (bus.ATA_TACK && bus.ATA_TEA) both++;
      if (!strobe) begin
        if (fall_at < 0) begin
          fall_at   = k;
          last_fall = cyc;
        end
        low_n++;
        if (bus.DATA_OE !== !rnw) oe_bad++;
      end
      if (bus.DATA_LATCH) begin
        latch_n++;
        latch_at = strobe ? -1 : low_n;
      end
      if (hold >= 0 && hold < 1000 && !strobe && low_n == t2 + hold) bus.IORDY = 1'b1;
      if (bus.ATA_TACK || bus.ATA_TEA) ended = 1;
    end
    chk("ack_seen", 32'(ended), 1);
    chk("strobe_high_at_ack", 32'(strobe), 1);
    chk("cs_hold_at_ack", 32'(bus.ATA_CS_EN), 1);
    chk("oe_hold_at_ack", 32'(bus.DATA_OE), 32'(!rnw));
    chk("tack", 32'(bus.ATA_TACK), 32'(!to_exp));
    chk("tea", 32'(bus.ATA_TEA), 32'(to_exp));
    chk("setup_cycles", 32'(fall_at - cs_at), 32'(t1));
    if (chk_cs) chk("cs_delay", 32'(cs_at), 1);
    if (to_exp) begin
      lo = t2 + 49; hi = t2 + 50;
    end else if (wait_exp) begin
      lo = t2 + hold + 2; hi = t2 + hold + 3;
    end else begin
      lo = t2; hi = t2;
    end
    chk($sformatf("strobe_width m=%0d w=%0d lo=%0d hi=%0d", mode, low_n, lo, hi),
        32'(low_n >= lo && low_n <= hi), 1);
    chk("latch_count", 32'(latch_n), 32'((rnw && !to_exp) ? 1 : 0));
    if (rnw && !to_exp) chk("latch_last_low", 32'(latch_at), 32'(low_n));
    chk("oe_during_strobe", 32'(oe_bad), 0);
    chk("wrong_strobe", 32'(wrong_n), 0);
    chk("tack_tea_excl", 32'(both), 0);
    @(negedge CLK40);
    chk("cs_dropped", 32'(bus.ATA_CS_EN), 0);
    chk("oe_dropped", 32'(bus.DATA_OE), 0);
    chk("ack_held", 32'({bus.ATA_TACK, bus.ATA_TEA}), 32'({!to_exp, to_exp}));
    bus.ATA_CYC = 1'b0;
    @(negedge CLK40);
    chk("ack_cleared", 32'({bus.ATA_TACK, bus.ATA_TEA}), 0);
    bus.IORDY = 1'b1;
  endtask

  initial begin
    int f1, low_n, acks;
    bus.ATA_CYC  = 1'b0;
    bus.RnW      = 1'b1;
    bus.PIO_MODE = 3'd0;
    bus.IORDY_EN = 1'b0;
    bus.IORDY    = 1'b1;
    idle(3);
    chk("reset_outputs", 32'(outs()), 32'(7'b0110000));
    RESET = 1'b0;

    // mode 4 read, IORDY ignored
    run_xfer(4, 1'b1, 1'b0, -1, 1'b1);

    // mode 0 writes back to back
    run_xfer(0, 1'b0, 1'b0, -1, 1'b1);
    f1 = last_fall;
    run_xfer(0, 1'b0, 1'b0, -1, 1'b0);
    chk($sformatf("b2b_spacing s=%0d", last_fall - f1), 32'((last_fall - f1) >= t0m(0)), 1);

    // mode 3 with IORDY low 10 cycles past T2, then stuck low
    run_xfer(3, 1'b1, 1'b1, 10, 1'b1);
    run_xfer(3, 1'b0, 1'b1, 1000, 1'b1);

    // PIO_MODE 6 behaves as mode 4
    run_xfer(6, 1'b1, 1'b0, -1, 1'b1);
    f1 = last_fall;
    run_xfer(6, 1'b0, 1'b1, -1, 1'b0);
    chk($sformatf("m6_spacing s=%0d", last_fall - f1), 32'((last_fall - f1) >= t0m(4)), 1);

    // abort mid-STROBE
    idle(12);
    bus.RnW = 1'b1; bus.PIO_MODE = 3'd2; bus.IORDY_EN = 1'b0;
    bus.ATA_CYC = 1'b1;
    low_n = 0;
    for (int i = 0; i < 30 && low_n < 2; i++) begin
      @(negedge CLK40);
      if (!bus.ATA_DIORn) low_n++;
    end
    chk("abort_reached_strobe", 32'(low_n), 2);
    bus.ATA_CYC = 1'b0;
    @(negedge CLK40);
    chk("abort_strobe_high", 32'(bus.ATA_DIORn), 1);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.ATA_TACK || bus.ATA_TEA) acks++;
      @(negedge CLK40);
    end
    chk("abort_no_ack", 32'(acks), 0);

    // randomized transfers against the timing tables
    for (int n = 0; n < 12; n++) begin
      int m, h;
      bit r, e;
      m = int'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      h = e ? -1 : (($urandom_range(0, 1) == 1) ? 1000 : -1);
      run_xfer(m, r, e, h, 1'b1);
    end

    // reset asserted in the middle of an IORDY wait
    idle(12);
    bus.RnW = 1'b1; bus.PIO_MODE = 3'd3; bus.IORDY_EN = 1'b1; bus.IORDY = 1'b0;
    idle(3);
    bus.ATA_CYC = 1'b1;
    low_n = 0;
    for (int i = 0; i < 40 && low_n < t2m(3) + 5; i++) begin
      @(negedge CLK40);
      if (!bus.ATA_DIORn) low_n++;
    end
    chk("wait_reached", 32'(low_n), 32'(t2m(3) + 5));
    RESET = 1'b1;
    @(negedge CLK40);
    chk("reset_mid_wait", 32'(outs()), 32'(7'b0110000));
    bus.ATA_CYC = 1'b0;
    bus.IORDY   = 1'b1;
    @(negedge CLK40);
    RESET = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK40);
      if (bus.ATA_TACK || bus.ATA_TEA || !bus.ATA_DIORn) acks++;
    end
    chk("no_ack_after_reset", 32'(acks), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/u110_ata_pio_sequencer.md
# u110_ata_pio_sequencer

Sequences one ATA PIO register/data transfer per CPU request: drives chip-select qualification, DIOR/DIOW strobe timing per PIO mode, honours IORDY, and raises ATA_TACK to the U110 cycle-termination logic. That logic emits a single TACKn pulse per ATA_TACK assertion and rearms only once ATA_TACK is negated. The block sits between the U110 address decode (ATA_CYC) and the ATA bus buffers, and is the sole source of ATA_TACK and ATA_TEA.

## Interface
- No parameters; timing constants live in the shared package.
- CLK40  in  1  40 MHz system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ATA_CYC  in  1  decoded ATA access; held high until the CPU cycle ends.
- RnW  in  1  1 = read, 0 = write; sampled at cycle start.
- PIO_MODE  in  3  PIO mode 0-4; values 5-7 are treated as 4. Sampled at cycle start.
- IORDY_EN  in  1  1 = honour IORDY (modes 3/4); sampled at cycle start.
- IORDY  in  1  raw ATA IORDY; asynchronous.
- ATA_CS_EN  out  1  qualifies the decoded CS0n/CS1n onto the bus.
- ATA_DIORn  out  1  read strobe, active low.
- ATA_DIOWn  out  1  write strobe, active low.
- DATA_OE  out  1  drives CPU data onto the ATA bus (writes).
- DATA_LATCH  out  1  one-cycle pulse that captures ATA read data.
- ATA_TACK  out  1  normal completion request to cycle termination; level.
- ATA_TEA  out  1  IORDY-timeout error request; level.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, DONE, RECOVER.
- IDLE: enter SETUP when all of the following hold: ATA_CYC=1, recovery count = 0, and ATA_TACK=ATA_TEA=0. On entry:
  - latch RnW, PIO_MODE and IORDY_EN;
  - load the counter with T1[mode];
  - set ATA_CS_EN=1;
  - set DATA_OE=!RnW.
- SETUP: count T1 cycles, then assert the strobe selected by RnW (DIORn or DIOWn = 0), load T2, and go to STROBE.
- STROBE: count T2 cycles. At terminal count:
  - if IORDY_EN=1 and synchronised IORDY=0, go to WAIT;
  - otherwise complete.
- WAIT: hold the strobe. The timeout counter runs.
  - Synchronised IORDY=1: complete.
  - Counter reaches 50 cycles (1250 ns): negate the strobe, assert ATA_TEA, go to DONE.
- Complete means:
  - reads: DATA_LATCH pulses in the last strobe-low cycle;
  - strobe negates next cycle, ATA_TACK=1 in that same cycle;
  - go to DONE.
- DONE: ATA_CS_EN and DATA_OE stay high one cycle after strobe negation (hold time), then drop. When ATA_CYC is sampled 0, negate ATA_TACK/ATA_TEA, load TREC[mode], go to RECOVER.
- RECOVER: count TREC to 0, then go to IDLE. An ATA_CYC that arrives during recovery is held off, not dropped.
- Abort: ATA_CYC=0 in SETUP/STROBE/WAIT negates the strobe next cycle, asserts no ATA_TACK and no ATA_TEA, and goes to RECOVER.
- ATA_TACK and ATA_TEA are mutually exclusive; never both high.
- Cycle counts (T1/T2/TREC, total = t0):
  - mode 0: 3/7/10 = 20 cycles;
  - mode 1: 2/6/8 = 16;
  - mode 2: 2/4/4 = 10;
  - mode 3: 1/4/3 = 8;
  - mode 4: 1/3/1 = 5.
- Counters are 4 bits (phase) and 6 bits (timeout), and saturate rather than wrap.

## Timing
- Reset values:
  - ATA_DIORn = ATA_DIOWn = 1;
  - all other outputs 0;
  - state IDLE, counters 0.
- RESET mid-cycle returns every output to its reset value at the next edge. No TACK is produced.
- Latency from ATA_CYC sampled high to strobe low is T1+1 cycles.
- IORDY passes through a 2-flop synchroniser, so it is seen 2-3 cycles after the pin changes.
- IORDY is ignored when IORDY_EN=0 or outside STROBE/WAIT.
- Strobe low width is exactly T2 cycles, or T2 plus the WAIT cycles.
- Minimum ATA_TACK width is 1 cycle. It follows ATA_CYC negation by exactly 1 cycle.
- Back-to-back cycles have a strobe-to-strobe spacing of at least t0[mode].

## Structure
- Package u110_ata_pkg holds:
  - the state enum;
  - the T1/T2/TREC lookup constants per mode;
  - TIMEOUT = 50;
  - the mode-clamp function.
- Sub-module u110_sync2: 2-flop synchroniser for IORDY; reusable for other async pins.
- The FSM and counters live in the top module.

## Test plan
- **Mode 4 read, IORDY_EN=0:**
  - CS_EN rises 1 cycle after ATA_CYC;
  - DIORn low 3 cycles;
  - DATA_LATCH pulses in strobe cycle 3;
  - ATA_TACK high from strobe negation until 1 cycle after ATA_CYC drops.
- **Mode 0 write:**
  - DATA_OE high across the cycle;
  - DIOWn low 7 cycles after 3 setup cycles;
  - a second ATA_CYC issued immediately is held off so that the strobe spacing is at least 20 cycles.
- **Mode 3 with IORDY held low 10 cycles past T2:**
  - strobe extended by about 10 cycles (plus 2-3 synchroniser cycles);
  - then normal ATA_TACK, with no ATA_TEA.
- **Mode 3 with IORDY stuck low:**
  - strobe negated after 50 WAIT cycles;
  - ATA_TEA=1 and ATA_TACK=0 held until ATA_CYC drops.
- **Abort and reset:**
  - ATA_CYC dropped mid-STROBE: strobe high next cycle, no TACK/TEA, RECOVER entered.
  - RESET asserted mid-WAIT: all outputs at reset values at the next edge.
- **PIO_MODE=6:** timing identical to mode 4, i.e. 1/3/1 cycles.
